gap_sampler: RTL and testbench
==============================

// Module: gap_sampler
// PURPOSE
//   Consumer side of the roll/random interface. On a spawn request it drives the
//   roll strobe of the random counter and samples the returned random word.
//   It reduces that word to a platform gap in [MIN_GAP, MIN_GAP+SPAN-1] by
//   iterative subtraction, then presents the gap to the platform spawner over a
//   valid/ack handshake.
// PARAMETERS
//   RAND_W       7   width of the random word from the random generator
//   GAP_W        7   width of the output gap
//   MIN_GAP     16   smallest gap produced
//   SPAN        40   number of distinct gaps; legal range 1..2^RAND_W
//   ROLL_CYCLES  3   cycles o_roll is held high per request; must be >=1
// PORTS
//   clk_gap          in   1       clock; all state updates on posedge
//   rst_gap          in   1       synchronous reset, active-high
//   i_req            in   1       spawn request; sampled only in IDLE
//   o_busy           out  1       high in every state except IDLE
//   o_roll           out  1       roll strobe to the random generator's i_roll
//   i_random_binary  in   RAND_W  random word; registered at the source
//   o_gap            out  GAP_W   gap value; stable while o_gap_valid
//   o_gap_valid      out  1       gap available
//   i_gap_ack        in   1       consumer accepts the gap
// BEHAVIOUR
//   Reset: state=IDLE; o_roll=0, o_busy=0, o_gap_valid=0, o_gap=0; reduce reg=0; roll counter=0.
//   FSM states: IDLE -> ROLL -> SAMPLE -> REDUCE -> OUT -> IDLE.
//   IDLE: if i_req=1, go to ROLL next cycle. i_req in any other state is dropped, not queued.
//   ROLL:
//     - o_roll=1 for exactly ROLL_CYCLES consecutive cycles, then go to SAMPLE.
//     - o_roll is a registered output, high only in ROLL.
//   SAMPLE:
//     - o_roll=0.
//     - The reduce reg latches i_random_binary, which by now reflects every roll edge.
//   REDUCE:
//     - Each cycle: if rem >= SPAN, rem <= rem - SPAN and stay.
//     - Else o_gap <= MIN_GAP + rem, o_gap_valid <= 1, go to OUT.
//     - At most floor((2^RAND_W-1)/SPAN)+1 cycles in REDUCE.
//   OUT:
//     - o_gap_valid and o_gap are held until i_gap_ack=1.
//     - On that edge go to IDLE; o_gap_valid=0 from the next cycle; o_gap keeps its value.
//     - If ack and req arrive in the same cycle, the req is dropped.
//   Latency, req edge to valid: 1 + ROLL_CYCLES + 1 + k cycles, where k = number of subtractions + 1.
//   Width rules:
//     - Reduce reg is RAND_W bits.
//     - The sum is computed at max(GAP_W, RAND_W)+1 bits and truncated to GAP_W.
//     - MIN_GAP+SPAN-1 < 2^GAP_W is required; violation is an elaboration error
//       (generate-time $error / illegal instance).
//   Boundaries:
//     - rem == SPAN reduces to 0, giving o_gap=MIN_GAP.
//     - rem == SPAN-1 exits REDUCE with no subtraction.
//     - SPAN == 2^RAND_W never subtracts.
//     - i_gap_ack outside OUT is ignored.
//     - Reset asserted in any state returns to IDLE on that edge.
//     - After reset mid-ROLL, o_roll=0 next cycle, with no further rolls.
//     - After reset mid-OUT, o_gap_valid=0 next cycle.
// STRUCTURE
//   Shared header jump_defs.vh holds:
//     - state encodings ST_IDLE..ST_OUT (3-bit localparams);
//     - the default MIN_GAP, SPAN and RAND_W shared with the random generator and
//       the platform spawner.
//   One sub-module, gap_mod_reduce: the iterative subtract-until-below-SPAN datapath.
//     - Inputs: load, value, step.
//     - Outputs: rem, done.
//   The FSM and handshake stay in gap_sampler. Instantiate with the random generator
//   wired as o_roll -> i_roll and o_random_binary -> i_random_binary.
// TESTING (defaults; bench models the source as a register it updates on o_roll)
//   1. Random=50, i_req 1 cycle, ack immediately:
//      - o_roll high exactly 3 cycles;
//      - one subtraction, then o_gap=26 with o_gap_valid at req+7;
//      - o_busy falls the cycle after ack.
//   2. Random=39 -> no subtraction -> o_gap=55 at req+6. Random=40 -> o_gap=16.
//   3. Random=127 -> 3 subtractions (127->87->47->7) -> o_gap=23 at req+9.
//   4. Hold i_gap_ack low 10 cycles in OUT:
//      - o_gap_valid stays 1 and o_gap stays stable;
//      - extra i_req pulses produce no o_roll;
//      - ack -> IDLE.
//   5. rst_gap on the 2nd ROLL cycle:
//      - o_roll=0 and o_busy=0 next cycle;
//      - total o_roll cycles = 2;
//      - a new i_req then completes normally.
//   6. i_gap_ack and i_req high together in OUT:
//      - valid drops;
//      - no new ROLL starts;
//      - a req two cycles later is accepted.

Source files
------------

// File: rtl/gap_sampler_pkg.sv
// Shared definitions for the gap sampler and its reduce datapath.
// Holds the default geometry (random word width, gap width, minimum gap,
// span, roll length) shared with the random generator and the platform
// spawner, the FSM state encoding and a small width helper.
package gap_sampler_pkg;

  localparam int DEF_RAND_W      = 7;
  localparam int DEF_GAP_W       = 7;
  localparam int DEF_MIN_GAP     = 16;
  localparam int DEF_SPAN        = 40;
  localparam int DEF_ROLL_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ROLL   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_REDUCE = 3'd3,
    ST_OUT    = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gap_mod_reduce.sv
// Iterative modulo datapath: loads a random word, then subtracts STEP_VAL
// once per enabled cycle until the remainder is below STEP_VAL.
// Ports:
//   clk   in   clock
//   rst   in   synchronous reset, active-high (clears rem)
//   load  in   capture value into rem
//   step  in   perform one subtraction if rem >= STEP_VAL
//   value in   RAND_W word to reduce
//   rem   out  RAND_W current remainder
//   done  out  rem < STEP_VAL
module gap_mod_reduce #(
  parameter int RAND_W   = 7,
  parameter int STEP_VAL = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [RAND_W-1:0] value,
  output logic [RAND_W-1:0] rem,
  output logic              done
);

  // One extra bit so STEP_VAL == 2^RAND_W is representable; done is then
  // always true and no subtraction ever happens.
  localparam logic [RAND_W:0] STEP_EXT = (RAND_W + 1)'(STEP_VAL);

  logic [RAND_W:0] diff;

  assign done = ({1'b0, rem} < STEP_EXT);
  assign diff = {1'b0, rem} - STEP_EXT;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
    end else if (load) begin
      rem <= value;
    end else if (step && !done) begin
      rem <= diff[RAND_W-1:0];
    end
  end

endmodule

// File: rtl/gap_sampler.sv
// Consumer side of the roll/random interface. On a spawn request it strobes
// the random generator for ROLL_CYCLES cycles, samples the random word,
// reduces it into [MIN_GAP, MIN_GAP+SPAN-1] and offers the gap over a
// valid/ack handshake.
// Ports:
//   clk_gap          in   clock
//   rst_gap          in   synchronous reset, active-high
//   i_req            in   spawn request, sampled only in IDLE
//   o_busy           out  high in every state except IDLE
//   o_roll           out  registered roll strobe to the random generator
//   i_random_binary  in   RAND_W random word from the generator
//   o_gap            out  GAP_W gap value, stable while o_gap_valid
//   o_gap_valid      out  gap available
//   i_gap_ack        in   consumer accepts the gap
//
// state     | meaning
// ST_IDLE   | waiting for i_req
// ST_ROLL   | o_roll high, counting ROLL_CYCLES
// ST_SAMPLE | capture i_random_binary into the reduce register
// ST_REDUCE | subtract SPAN until remainder < SPAN, then load o_gap
// ST_OUT    | o_gap_valid held until i_gap_ack
module gap_sampler
  import gap_sampler_pkg::*;
#(
  parameter int RAND_W      = DEF_RAND_W,
  parameter int GAP_W       = DEF_GAP_W,
  parameter int MIN_GAP     = DEF_MIN_GAP,
  parameter int SPAN        = DEF_SPAN,
  parameter int ROLL_CYCLES = DEF_ROLL_CYCLES
) (
  input  logic              clk_gap,
  input  logic              rst_gap,
  input  logic              i_req,
  output logic              o_busy,
  output logic              o_roll,
  input  logic [RAND_W-1:0] i_random_binary,
  output logic [GAP_W-1:0]  o_gap,
  output logic              o_gap_valid,
  input  logic              i_gap_ack
);

  localparam int SUM_W = max_int(GAP_W, RAND_W) + 1;
  localparam int CNT_W = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;

  if (MIN_GAP + SPAN - 1 >= (1 << GAP_W)) begin : g_gap_range_err
    $error("gap_sampler: MIN_GAP+SPAN-1 does not fit in GAP_W bits");
  end
  if (SPAN < 1 || SPAN > (1 << RAND_W)) begin : g_span_err
    $error("gap_sampler: SPAN must be in 1..2^RAND_W");
  end
  if (ROLL_CYCLES < 1) begin : g_roll_err
    $error("gap_sampler: ROLL_CYCLES must be >= 1");
  end

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               roll_d, valid_d, gap_load;
  logic               load, step, done;
  logic [RAND_W-1:0]  rem;
  logic [GAP_W-1:0]   gap_d;

  gap_mod_reduce #(
    .RAND_W   (RAND_W),
    .STEP_VAL (SPAN)
  ) u_reduce (
    .clk   (clk_gap),
    .rst   (rst_gap),
    .load  (load),
    .step  (step),
    .value (i_random_binary),
    .rem   (rem),
    .done  (done)
  );

  // Sum at the wider width, then truncate to the gap width.
  assign gap_d  = GAP_W'(SUM_W'(MIN_GAP) + SUM_W'(rem));
  assign o_busy = (state != ST_IDLE);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    roll_d   = 1'b0;
    valid_d  = o_gap_valid;
    gap_load = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req) begin
          state_d = ST_ROLL;
          roll_d  = 1'b1;
          cnt_d   = CNT_W'(ROLL_CYCLES - 1);
        end
      end
      ST_ROLL: begin
        // Down-counter: terminal count ends the strobe on this edge.
        if (cnt == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          roll_d = 1'b1;
          cnt_d  = cnt - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        load    = 1'b1;
        state_d = ST_REDUCE;
      end
      ST_REDUCE: begin
        if (done) begin
          gap_load = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_OUT;
        end else begin
          step = 1'b1;
        end
      end
      ST_OUT: begin
        if (i_gap_ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_gap) begin
    if (rst_gap) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      o_roll      <= 1'b0;
      o_gap_valid <= 1'b0;
      o_gap       <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      o_roll      <= roll_d;
      o_gap_valid <= valid_d;
      if (gap_load) o_gap <= gap_d;
    end
  end

endmodule

// File: tb/tb_gap_sampler.sv
// Self-checking bench for gap_sampler. The random source is modelled as a
// register updated on every edge where o_roll is high; expected gaps and
// latencies come from plain modulo/division arithmetic.
module tb_gap_sampler;

  localparam int R   = 3;
  localparam int MIN = 16;
  localparam int SP  = 40;

  logic       clk_gap = 1'b0;
  logic       rst_gap;
  logic       i_req;
  logic       i_gap_ack;
  logic       o_busy, o_roll, o_gap_valid;
  logic [6:0] o_gap;
  logic [6:0] src = '0;
  logic [6:0] fixed_val = '0;
  bit         random_mode = 1'b0;
  int         roll_count = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk_gap = ~clk_gap;

  gap_sampler dut (
    .clk_gap         (clk_gap),
    .rst_gap         (rst_gap),
    .i_req           (i_req),
    .o_busy          (o_busy),
    .o_roll          (o_roll),
    .i_random_binary (src),
    .o_gap           (o_gap),
    .o_gap_valid     (o_gap_valid),
    .i_gap_ack       (i_gap_ack)
  );

  always @(posedge clk_gap) begin
    if (o_roll) begin
      roll_count <= roll_count + 1;
      src        <= random_mode ? 7'($urandom_range(0, 127)) : fixed_val;
    end
  end

  function automatic int exp_gap(input int v);
    return MIN + (v % SP);
  endfunction

  function automatic int exp_lat(input int v);
    return 1 + R + 1 + (v / SP) + 1;
  endfunction

  // Pulse i_req and wait (bounded) for o_gap_valid; lat=-1 on timeout.
  task automatic run_txn(output int lat, output int rolls, output logic [6:0] gap);
    int r0;
    r0 = roll_count;
    lat = -1;
    i_req = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_gap);
      i_req = 1'b0;
      if (o_gap_valid) begin
        lat = n;
        break;
      end
    end
    gap = o_gap;
    rolls = roll_count - r0;
  endtask

  task automatic do_ack();
    i_gap_ack = 1'b1;
    @(negedge clk_gap);
    i_gap_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_gap = 1'b1;
    i_req = 1'b0;
    i_gap_ack = 1'b0;
    repeat (3) @(negedge clk_gap);
    checks++; if (o_roll !== 1'b0) begin failures++; $display("FAIL reset_roll got=%b exp=0", o_roll); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_gap_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_gap_valid); end
    checks++; if (o_gap !== 7'd0) begin failures++; $display("FAIL reset_gap got=%0d exp=0", o_gap); end
    rst_gap = 1'b0;
    @(negedge clk_gap);
  endtask

  task automatic test_basic();
    int lat, rolls;
    logic [6:0] gap;
    fixed_val = 7'd50;
    run_txn(lat, rolls, gap);
    checks++; if (rolls != R) begin failures++; $display("FAIL basic_rolls got=%0d exp=%0d", rolls, R); end
    checks++; if (lat != 7) begin failures++; $display("FAIL basic_latency got=%0d exp=7", lat); end
    checks++; if (gap !== 7'd26) begin failures++; $display("FAIL basic_gap got=%0d exp=26", gap); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_out got=%b exp=1", o_busy); end
    do_ack();
    checks++; if (o_gap_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%b exp=0", o_gap_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_drop got=%b exp=0", o_busy); end
    checks++; if (o_gap !== 7'd26) begin failures++; $display("FAIL basic_gap_keep got=%0d exp=26", o_gap); end
  endtask

  task automatic test_boundaries();
    int vals[3] = '{39, 40, 127};
    int lat, rolls;
    logic [6:0] gap;
    for (int i = 0; i < 3; i++) begin
      fixed_val = 7'(vals[i]);
      run_txn(lat, rolls, gap);
      checks++; if (lat != exp_lat(vals[i])) begin failures++; $display("FAIL bound_latency v=%0d got=%0d exp=%0d", vals[i], lat, exp_lat(vals[i])); end
      checks++; if (gap !== 7'(exp_gap(vals[i]))) begin failures++; $display("FAIL bound_gap v=%0d got=%0d exp=%0d", vals[i], gap, exp_gap(vals[i])); end
      do_ack();
    end
  endtask

  task automatic test_hold();
    int lat, rolls, r0;
    logic [6:0] gap;
    fixed_val = 7'd90;
    run_txn(lat, rolls, gap);
    checks++; if (gap !== 7'(exp_gap(90))) begin failures++; $display("FAIL hold_gap got=%0d exp=%0d", gap, exp_gap(90)); end
    r0 = roll_count;
    for (int c = 0; c < 10; c++) begin
      i_req = (c % 2 == 0);
      @(negedge clk_gap);
      checks++; if (o_gap_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, o_gap_valid); end
      checks++; if (o_gap !== 7'(exp_gap(90))) begin failures++; $display("FAIL hold_stable cyc=%0d got=%0d exp=%0d", c, o_gap, exp_gap(90)); end
    end
    i_req = 1'b0;
    checks++; if (roll_count != r0) begin failures++; $display("FAIL hold_no_roll got=%0d exp=%0d", roll_count - r0, 0); end
    do_ack();
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL hold_idle got=%b exp=0", o_busy); end
  endtask

  task automatic test_reset_roll();
    int lat, rolls, r0;
    logic [6:0] gap;
    fixed_val = 7'd5;
    r0 = roll_count;
    i_req = 1'b1;
    @(negedge clk_gap);
    i_req = 1'b0;
    @(negedge clk_gap);
    rst_gap = 1'b1;
    @(negedge clk_gap);
    rst_gap = 1'b0;
    checks++; if (o_roll !== 1'b0) begin failures++; $display("FAIL rstroll_roll got=%b exp=0", o_roll); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstroll_busy got=%b exp=0", o_busy); end
    repeat (4) @(negedge clk_gap);
    checks++; if (roll_count - r0 != 2) begin failures++; $display("FAIL rstroll_count got=%0d exp=2", roll_count - r0); end
    fixed_val = 7'd77;
    run_txn(lat, rolls, gap);
    checks++; if (lat != exp_lat(77)) begin failures++; $display("FAIL rstroll_lat got=%0d exp=%0d", lat, exp_lat(77)); end
    checks++; if (gap !== 7'(exp_gap(77))) begin failures++; $display("FAIL rstroll_gap got=%0d exp=%0d", gap, exp_gap(77)); end
    do_ack();
  endtask

  task automatic test_reset_out();
    int lat, rolls;
    logic [6:0] gap;
    fixed_val = 7'd100;
    run_txn(lat, rolls, gap);
    rst_gap = 1'b1;
    @(negedge clk_gap);
    rst_gap = 1'b0;
    checks++; if (o_gap_valid !== 1'b0) begin failures++; $display("FAIL rstout_valid got=%b exp=0", o_gap_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstout_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_ack_req();
    int lat, rolls;
    logic [6:0] gap;
    fixed_val = 7'd60;
    run_txn(lat, rolls, gap);
    i_gap_ack = 1'b1;
    i_req = 1'b1;
    @(negedge clk_gap);
    i_gap_ack = 1'b0;
    i_req = 1'b0;
    checks++; if (o_gap_valid !== 1'b0) begin failures++; $display("FAIL ackreq_valid got=%b exp=0", o_gap_valid); end
    checks++; if (o_roll !== 1'b0) begin failures++; $display("FAIL ackreq_roll got=%b exp=0", o_roll); end
    @(negedge clk_gap);
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL ackreq_busy got=%b exp=0", o_busy); end
    fixed_val = 7'd13;
    run_txn(lat, rolls, gap);
    checks++; if (lat != exp_lat(13)) begin failures++; $display("FAIL ackreq_lat got=%0d exp=%0d", lat, exp_lat(13)); end
    checks++; if (gap !== 7'(exp_gap(13))) begin failures++; $display("FAIL ackreq_gap got=%0d exp=%0d", gap, exp_gap(13)); end
    do_ack();
  endtask

  task automatic test_ack_idle();
    logic [6:0] g0;
    g0 = o_gap;
    i_gap_ack = 1'b1;
    repeat (3) @(negedge clk_gap);
    i_gap_ack = 1'b0;
    checks++; if (o_busy !== 1'b0 || o_gap_valid !== 1'b0) begin failures++; $display("FAIL ackidle_state busy=%b valid=%b exp=0/0", o_busy, o_gap_valid); end
    checks++; if (o_gap !== g0) begin failures++; $display("FAIL ackidle_gap got=%0d exp=%0d", o_gap, g0); end
  endtask

  task automatic test_random();
    int lat, rolls, v, dly;
    logic [6:0] gap;
    random_mode = 1'b1;
    for (int it = 0; it < 25; it++) begin
      run_txn(lat, rolls, gap);
      v = int'(src);
      checks++; if (rolls != R) begin failures++; $display("FAIL rand_rolls it=%0d got=%0d exp=%0d", it, rolls, R); end
      checks++; if (lat != exp_lat(v)) begin failures++; $display("FAIL rand_lat it=%0d v=%0d got=%0d exp=%0d", it, v, lat, exp_lat(v)); end
      checks++; if (gap !== 7'(exp_gap(v))) begin failures++; $display("FAIL rand_gap it=%0d v=%0d got=%0d exp=%0d", it, v, gap, exp_gap(v)); end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge clk_gap);
      checks++; if (o_gap_valid !== 1'b1 || o_gap !== 7'(exp_gap(v))) begin failures++; $display("FAIL rand_hold it=%0d valid=%b gap=%0d exp=1/%0d", it, o_gap_valid, o_gap, exp_gap(v)); end
      do_ack();
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rand_idle it=%0d got=%b exp=0", it, o_busy); end
      repeat ($urandom_range(0, 2)) @(negedge clk_gap);
    end
    random_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_hold();
    test_reset_roll();
    test_reset_out();
    test_ack_req();
    test_ack_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
